// File: rtl/iob_zrle_pkg.sv
// iob_zrle_pkg: shared token encoding, run-length defaults and encoder state view for the zero-run-length encoder
package iob_zrle_pkg;
  localparam int RUN_W_DEF = 8;
  localparam int RUN_MAX_DEF = (1 << RUN_W_DEF) - 1;
  localparam logic IS_RUN = 1'b1;
  localparam logic IS_LIT = 1'b0;
  typedef enum logic [1:0] {ST_LIT, ST_RUN, ST_PEND} zrle_state_e;
endpackage

// File: rtl/iob_zrle_slot.sv
// iob_zrle_slot: one-entry registered token slot with valid/ready hold semantics
module iob_zrle_slot
  import iob_zrle_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              cke,
  input  logic              arst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_is_run,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              is_run
);
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      valid  <= 1'b0;
      data   <= '0;
      is_run <= IS_LIT;
    end else if (cke) begin
      if (clr) begin
        valid  <= 1'b0;
        data   <= '0;
        is_run <= IS_LIT;
      end else if (load) begin
        valid  <= 1'b1;
        data   <= load_data;
        is_run <= load_is_run;
      end else if (ready) begin
        valid  <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/iob_zrle.sv
// iob_zrle: zero-run-length encoder emitting literal tokens and saturating zero-run tokens
module iob_zrle
  import iob_zrle_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RUN_W  = RUN_W_DEF
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              arst_n_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              flush_i,
  output logic [DATA_W-1:0] data_o,
  output logic              is_run_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              run_pending_o
);
  localparam logic [RUN_W-1:0] RUN_MAX = '1;
  logic [RUN_W-1:0]  run_cnt, run_cnt_n;
  logic              pend_valid, pend_valid_n;
  logic [DATA_W-1:0] pend_data, pend_data_n;
  logic              slot_free, accept, zero, load, load_is_run;
  logic [DATA_W-1:0] load_data;
  zrle_state_e       state;
  assign slot_free     = !valid_o || ready_i;
  assign ready_o       = slot_free && !pend_valid && !flush_i;
  assign accept        = valid_i && ready_o && cke_i;
  assign zero          = data_i == '0;
  assign run_pending_o = state != ST_LIT;
  always_comb state = pend_valid ? ST_PEND : (run_cnt != '0 ? ST_RUN : ST_LIT);
  always_comb begin
    run_cnt_n    = run_cnt;
    pend_valid_n = pend_valid;
    pend_data_n  = pend_data;
    load         = 1'b0;
    load_is_run  = IS_LIT;
    load_data    = '0;
    if (state == ST_PEND) begin
      if (slot_free) begin
        load         = 1'b1;
        load_data    = pend_data;
        pend_valid_n = 1'b0;
      end
    end else if (accept && zero) begin
      if (run_cnt == RUN_MAX - 1'b1) begin
        load        = 1'b1;
        load_is_run = IS_RUN;
        load_data   = DATA_W'(RUN_MAX);
        run_cnt_n   = '0;
      end else begin
        run_cnt_n = run_cnt + 1'b1;
      end
    end else if (accept) begin
      load = 1'b1;
      if (state == ST_LIT) begin
        load_data = data_i;
      end else begin
        load_is_run  = IS_RUN;
        load_data    = DATA_W'(run_cnt);
        run_cnt_n    = '0;
        pend_valid_n = 1'b1;
        pend_data_n  = data_i;
      end
    end else if (flush_i && state == ST_RUN && slot_free) begin
      load        = 1'b1;
      load_is_run = IS_RUN;
      load_data   = DATA_W'(run_cnt);
      run_cnt_n   = '0;
    end
  end
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      run_cnt    <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
    end else if (cke_i) begin
      if (rst_i) begin
        run_cnt    <= '0;
        pend_valid <= 1'b0;
        pend_data  <= '0;
      end else begin
        run_cnt    <= run_cnt_n;
        pend_valid <= pend_valid_n;
        pend_data  <= pend_data_n;
      end
    end
  end
  iob_zrle_slot #(.DATA_W(DATA_W)) u_slot (
    .clk         (clk_i),
    .cke         (cke_i),
    .arst_n      (arst_n_i),
    .clr         (rst_i),
    .load        (load),
    .load_data   (load_data),
    .load_is_run (load_is_run),
    .ready       (ready_i),
    .valid       (valid_o),
    .data        (data_o),
    .is_run      (is_run_o)
  );
endmodule

// File: tb/tb_iob_zrle.sv
// tb_iob_zrle: randomized and directed checks of iob_zrle against a token-list reference model
module tb_iob_zrle;
  localparam int DW = 32;
  localparam int RW = 4;
  localparam int RMAX = 15;
  localparam logic [32:0] FLUSH = 33'h1_0000_0000;
  logic clk = 1'b0;
  logic cke_i = 1'b1, arst_n_i = 1'b1, rst_i = 1'b0;
  logic valid_i = 1'b0, flush_i = 1'b0, ready_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic ready_o, is_run_o, valid_o, run_pending_o;
  logic [DW-1:0] data_o;
  int errs = 0, checks = 0;
  logic [32:0] stream_q[$], exp_q[$], rcv_q[$];

  always #5 clk = ~clk;

  iob_zrle #(.DATA_W(DW), .RUN_W(RW)) dut (
    .clk_i(clk), .cke_i(cke_i), .arst_n_i(arst_n_i), .rst_i(rst_i),
    .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o), .flush_i(flush_i),
    .data_o(data_o), .is_run_o(is_run_o), .valid_o(valid_o), .ready_i(ready_i),
    .run_pending_o(run_pending_o)
  );

  function automatic logic [32:0] run_tok(input int n);
    return {1'b1, 32'(n)};
  endfunction

  function automatic logic [32:0] lit_tok(input logic [31:0] d);
    return {1'b0, d};
  endfunction

  // one clock: drive at negedge, sample mid-cycle, return just after the rising edge
  task automatic step(input logic v, input logic [31:0] d, input logic r, input logic f,
                      input logic ck, output logic acc);
    @(negedge clk);
    valid_i = v; data_i = d; ready_i = r; flush_i = f; cke_i = ck;
    #1;
    acc = valid_i && ready_o && cke_i;
    if (valid_o && ready_i && cke_i) rcv_q.push_back({is_run_o, data_o});
    @(posedge clk);
    #1;
  endtask

  // reference: count zeros, saturate at RMAX, close runs before literals and on flush
  task automatic model_tokens();
    int c;
    c = 0;
    exp_q.delete();
    foreach (stream_q[i]) begin
      if (stream_q[i][32]) begin
        if (c > 0) exp_q.push_back(run_tok(c));
        c = 0;
      end else if (stream_q[i][31:0] == 0) begin
        c++;
        if (c == RMAX) begin
          exp_q.push_back(run_tok(RMAX));
          c = 0;
        end
      end else begin
        if (c > 0) exp_q.push_back(run_tok(c));
        c = 0;
        exp_q.push_back(lit_tok(stream_q[i][31:0]));
      end
    end
  endtask

  task automatic drive_stream(input int pr, input int pc);
    logic acc;
    int n;
    rcv_q.delete();
    foreach (stream_q[i]) begin
      n = 0;
      if (stream_q[i][32]) begin
        do begin
          step(1'b0, '0, $urandom_range(99) < pr, 1'b1, $urandom_range(99) < pc, acc);
          n++;
        end while (run_pending_o && n < 300);
        if (run_pending_o) begin
          checks++; errs++;
          $display("FAIL flush_timeout: run_pending_o=%b want 0", run_pending_o);
        end
      end else begin
        acc = 1'b0;
        while (!acc && n < 300) begin
          step(1'b1, stream_q[i][31:0], $urandom_range(99) < pr, 1'b0, $urandom_range(99) < pc, acc);
          n++;
        end
        if (!acc) begin
          checks++; errs++;
          $display("FAIL accept_timeout: accepted=%b want 1", acc);
        end
      end
    end
    n = 0;
    do begin
      step(1'b0, '0, 1'b1, 1'b0, 1'b1, acc);
      n++;
    end while (valid_o && n < 20);
  endtask

  task automatic test_reset();
    #2 arst_n_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (valid_o !== 1'b0) begin errs++; $display("FAIL rst_valid: got %b want 0", valid_o); end
    checks++; if (data_o !== 32'h0) begin errs++; $display("FAIL rst_data: got %h want 0", data_o); end
    checks++; if (is_run_o !== 1'b0) begin errs++; $display("FAIL rst_is_run: got %b want 0", is_run_o); end
    checks++; if (run_pending_o !== 1'b0) begin errs++; $display("FAIL rst_pending: got %b want 0", run_pending_o); end
    checks++; if (ready_o !== 1'b1) begin errs++; $display("FAIL rst_ready: got %b want 1", ready_o); end
    @(negedge clk);
    arst_n_i = 1'b1;
  endtask

  task automatic test_literals();
    logic acc;
    logic [31:0] vals[3];
    vals = '{32'd5, 32'd7, 32'hFFFF_FFFD};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, vals[i], 1'b1, 1'b0, 1'b1, acc);
      checks++; if (acc !== 1'b1) begin errs++; $display("FAIL lit_accept%0d: got %b want 1", i, acc); end
      checks++; if ({valid_o, is_run_o, data_o} !== {2'b10, vals[i]})
        begin errs++; $display("FAIL lit_out%0d: got v=%b r=%b d=%h want v=1 r=0 d=%h", i, valid_o, is_run_o, data_o, vals[i]); end
    end
    step(1'b0, '0, 1'b1, 1'b0, 1'b1, acc);
    checks++; if (valid_o !== 1'b0) begin errs++; $display("FAIL lit_idle: valid_o=%b want 0", valid_o); end
  endtask

  task automatic test_run_literal();
    logic acc;
    repeat (3) step(1'b1, '0, 1'b1, 1'b0, 1'b1, acc);
    checks++; if ({valid_o, run_pending_o} !== 2'b01) begin errs++; $display("FAIL rl_zeros: v=%b pend=%b want v=0 pend=1", valid_o, run_pending_o); end
    step(1'b1, 32'd9, 1'b1, 1'b0, 1'b1, acc);
    checks++; if ({valid_o, is_run_o, data_o} !== {2'b11, 32'd3})
      begin errs++; $display("FAIL rl_run: got v=%b r=%b d=%h want v=1 r=1 d=3", valid_o, is_run_o, data_o); end
    checks++; if (ready_o !== 1'b0) begin errs++; $display("FAIL rl_pend_ready: got %b want 0", ready_o); end
    step(1'b0, '0, 1'b1, 1'b0, 1'b1, acc);
    checks++; if ({valid_o, is_run_o, data_o} !== {2'b10, 32'd9})
      begin errs++; $display("FAIL rl_lit: got v=%b r=%b d=%h want v=1 r=0 d=9", valid_o, is_run_o, data_o); end
    checks++; if ({ready_o, run_pending_o} !== 2'b10) begin errs++; $display("FAIL rl_after: ready=%b pend=%b want 1 0", ready_o, run_pending_o); end
    step(1'b0, '0, 1'b1, 1'b0, 1'b1, acc);
  endtask

  task automatic test_saturation();
    stream_q.delete();
    repeat (20) stream_q.push_back(33'h0);
    stream_q.push_back(33'h1);
    stream_q.push_back(FLUSH);
    drive_stream(100, 100);
    exp_q = '{run_tok(15), run_tok(5), lit_tok(32'd1)};
    checks++; if (rcv_q.size() != exp_q.size()) begin errs++; $display("FAIL sat_count: got %0d want %0d", rcv_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
      checks++; if (rcv_q[i] !== exp_q[i]) begin errs++; $display("FAIL sat_tok%0d: got %h want %h", i, rcv_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_flush();
    logic acc;
    int n;
    rcv_q.delete();
    repeat (4) step(1'b1, '0, 1'b1, 1'b0, 1'b1, acc);
    checks++; if (run_pending_o !== 1'b1) begin errs++; $display("FAIL fl_pending: got %b want 1", run_pending_o); end
    n = 0;
    do begin
      step(1'b0, '0, 1'b1, 1'b1, 1'b1, acc);
      n++;
    end while (run_pending_o && n < 10);
    checks++; if (run_pending_o !== 1'b0) begin errs++; $display("FAIL fl_clear: run_pending_o=%b want 0", run_pending_o); end
    checks++; if (ready_o !== 1'b0) begin errs++; $display("FAIL fl_ready: got %b want 0 while flushing", ready_o); end
    repeat (3) step(1'b0, '0, 1'b1, 1'b0, 1'b1, acc);
    repeat (3) step(1'b0, '0, 1'b1, 1'b1, 1'b1, acc);
    checks++; if (valid_o !== 1'b0) begin errs++; $display("FAIL fl_noop: valid_o=%b want 0", valid_o); end
    checks++; if (rcv_q.size() != 1) begin errs++; $display("FAIL fl_count: got %0d want 1", rcv_q.size()); end
    else begin
      checks++; if (rcv_q[0] !== run_tok(4)) begin errs++; $display("FAIL fl_tok: got %h want %h", rcv_q[0], run_tok(4)); end
    end
  endtask

  task automatic test_backpressure();
    logic acc;
    int n;
    rcv_q.delete();
    step(1'b1, 32'd12, 1'b1, 1'b0, 1'b1, acc);
    checks++; if (acc !== 1'b1) begin errs++; $display("FAIL bp_accept12: got %b want 1", acc); end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'd13, 1'b0, 1'b0, 1'b1, acc);
      checks++; if (acc !== 1'b0) begin errs++; $display("FAIL bp_stall%0d: accepted=%b want 0", i, acc); end
      checks++; if ({valid_o, data_o} !== {1'b1, 32'd12}) begin errs++; $display("FAIL bp_hold%0d: v=%b d=%h want v=1 d=c", i, valid_o, data_o); end
    end
    n = 0; acc = 1'b0;
    while (!acc && n < 10) begin step(1'b1, 32'd13, 1'b1, 1'b0, 1'b1, acc); n++; end
    n = 0;
    do begin step(1'b0, '0, 1'b1, 1'b0, 1'b1, acc); n++; end while (valid_o && n < 10);
    checks++; if (rcv_q.size() != 2) begin errs++; $display("FAIL bp_count: got %0d want 2", rcv_q.size()); end
    else begin
      checks++; if ({rcv_q[0], rcv_q[1]} !== {lit_tok(32'd12), lit_tok(32'd13)})
        begin errs++; $display("FAIL bp_order: got %h %h want 0c 0d", rcv_q[0], rcv_q[1]); end
    end
  endtask

  task automatic check_zero_four(input string tag);
    stream_q = '{33'h0, 33'h4, FLUSH};
    drive_stream(100, 100);
    checks++; if (rcv_q.size() != 2) begin errs++; $display("FAIL %s_count: got %0d want 2", tag, rcv_q.size()); end
    else begin
      checks++; if ({rcv_q[0], rcv_q[1]} !== {run_tok(1), lit_tok(32'd4)})
        begin errs++; $display("FAIL %s_tokens: got %h %h want run1 lit4", tag, rcv_q[0], rcv_q[1]); end
    end
  endtask

  task automatic test_async_reset();
    logic acc;
    repeat (6) step(1'b1, '0, 1'b1, 1'b0, 1'b1, acc);
    checks++; if (run_pending_o !== 1'b1) begin errs++; $display("FAIL ar_pre: pending=%b want 1", run_pending_o); end
    #2 valid_i = 1'b0; arst_n_i = 1'b0;
    #1;
    checks++; if ({valid_o, run_pending_o} !== 2'b00) begin errs++; $display("FAIL ar_clear: v=%b pend=%b want 0 0", valid_o, run_pending_o); end
    @(negedge clk); #1 arst_n_i = 1'b1;
    check_zero_four("ar");
    step(1'b1, 32'd77, 1'b0, 1'b0, 1'b1, acc);
    checks++; if ({valid_o, data_o} !== {1'b1, 32'd77}) begin errs++; $display("FAIL ar_lit: v=%b d=%h want 1 4d", valid_o, data_o); end
    #2 valid_i = 1'b0; arst_n_i = 1'b0;
    #1;
    checks++; if ({valid_o, data_o} !== 33'h0) begin errs++; $display("FAIL ar_slot: v=%b d=%h want 0 0", valid_o, data_o); end
    @(negedge clk); #1 arst_n_i = 1'b1;
  endtask

  task automatic test_sync_reset();
    logic acc;
    repeat (6) step(1'b1, '0, 1'b1, 1'b0, 1'b1, acc);
    rst_i = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
    checks++; if (run_pending_o !== 1'b1) begin errs++; $display("FAIL sr_cke_low: pending=%b want 1", run_pending_o); end
    step(1'b0, '0, 1'b1, 1'b0, 1'b1, acc);
    checks++; if ({valid_o, run_pending_o} !== 2'b00) begin errs++; $display("FAIL sr_clear: v=%b pend=%b want 0 0", valid_o, run_pending_o); end
    rst_i = 1'b0;
    check_zero_four("sr");
    step(1'b1, 32'd55, 1'b0, 1'b0, 1'b1, acc);
    rst_i = 1'b1;
    checks++; if (valid_o !== 1'b1) begin errs++; $display("FAIL sr_lit: v=%b want 1 before edge", valid_o); end
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
    checks++; if ({valid_o, data_o} !== 33'h0) begin errs++; $display("FAIL sr_slot: v=%b d=%h want 0 0", valid_o, data_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] d;
    for (int r = 0; r < 4; r++) begin
      stream_q.delete();
      for (int i = 0; i < 80; i++) begin
        if ($urandom_range(99) < 5) stream_q.push_back(FLUSH);
        else if ($urandom_range(99) < 4) repeat ($urandom_range(40, 14)) stream_q.push_back(33'h0);
        else begin
          d = ($urandom_range(99) < 55) ? 32'h0 : ($urandom_range(1) ? 32'($urandom_range(300, 1)) : $urandom);
          stream_q.push_back({1'b0, d});
        end
      end
      stream_q.push_back(FLUSH);
      drive_stream(60 + 10 * r, 85);
      model_tokens();
      checks++; if (rcv_q.size() != exp_q.size()) begin errs++; $display("FAIL rnd%0d_count: got %0d want %0d", r, rcv_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
        checks++; if (rcv_q[i] !== exp_q[i]) begin errs++; $display("FAIL rnd%0d_tok%0d: got %h want %h", r, i, rcv_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_literals();
    test_run_literal();
    test_saturation();
    test_flush();
    test_backpressure();
    test_async_reset();
    test_sync_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
